// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle datapath: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_retired;
  logic               w_retire;
  logic               w_bad_op;

  logic               w_irwrite, w_regwrite, w_memwrite, w_pcwrite, w_pcwritecond;

  // Next-state and retire/illegal events
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    w_bad_op = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_retire = 1'b1;
      S_MEMWR: begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_retire = 1'b1;
      S_BRANCH: w_retire = 1'b1;
      S_JUMP:   w_retire = 1'b1;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_retire = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_bad_op) r_illegal <= 1'b1;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Moore output decode; only the FETCH strobes look at mem_ready
  always_comb begin
    w_irwrite     = 1'b0;
    w_regwrite    = 1'b0;
    w_memwrite    = 1'b0;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    MemRead       = 1'b0;
    IorD          = 1'b0;
    PCSource      = 2'b00;
    ALUOp         = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        MemtoReg   = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        IorD       = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        RegDst     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        w_pcwritecond = 1'b1;
        PCSource      = 2'b01;
      end
      S_JUMP: begin
        w_pcwrite = 1'b1;
        PCSource  = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are suppressed in the cycle reset is held, so an
  // instruction interrupted by reset never commits a partial write.
  assign IRWrite     = w_irwrite     & reset;
  assign RegWrite    = w_regwrite    & reset;
  assign MemWrite    = w_memwrite    & reset;
  assign PCWrite     = w_pcwrite     & reset;
  assign PCWriteCond = w_pcwritecond & reset;

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver pushes per-cycle expectations,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite, IorD;
  logic             PCWrite, PCWriteCond, ALUSrcA, illegal;
  logic [1:0]       PCSource, ALUOp, ALUSrcB;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .state(state), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    logic [3:0]       st;
    logic             mr;
    logic             rn;
    logic             ill;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  logic             e_ill;
  logic [CNT_W-1:0] e_ret;

  // Control vector {IRWrite,RegWrite,RegDst,MemtoReg,MemRead,MemWrite,IorD,
  // PCWrite,PCWriteCond,PCSource,ALUOp,ALUSrcA,ALUSrcB} from the state table.
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr, input logic rn);
    logic irw, rw, rd, m2r, mrd, mwr, iod, pcw, pcc, asa;
    logic [1:0] pcs, aop, asb;
    {irw, rw, rd, m2r, mrd, mwr, iod, pcw, pcc, asa} = '0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (!rn) begin irw = 0; rw = 0; mwr = 0; pcw = 0; pcc = 0; end
    return {irw, rw, rd, m2r, mrd, mwr, iod, pcw, pcc, pcs, aop, asa, asb};
  endfunction

  // One cycle: inputs applied just after the edge, expectation queued for it
  task automatic step(input logic rn, input logic mr, input logic [5:0] op, input logic [3:0] st);
    exp_t e;
    reset = rn; mem_ready = mr; opcode = op;
    e.st = st; e.mr = mr; e.rn = rn; e.ill = e_ill; e.ret = e_ret;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_instr(input logic [5:0] op);
    case (op)
      OP_R:    begin step(1,1,op,0); step(1,1,op,1); step(1,1,op,6); step(1,1,op,7); end
      OP_LW:   begin step(1,1,op,0); step(1,1,op,1); step(1,1,op,2); step(1,1,op,3); step(1,1,op,4); end
      OP_SW:   begin step(1,1,op,0); step(1,1,op,1); step(1,1,op,2); step(1,1,op,5); end
      OP_BEQ:  begin step(1,1,op,0); step(1,1,op,1); step(1,1,op,8); end
      OP_J:    begin step(1,1,op,0); step(1,1,op,1); step(1,1,op,9); end
      OP_ADDI: begin step(1,1,op,0); step(1,1,op,1); step(1,1,op,10); step(1,1,op,11); end
      default: begin step(1,1,op,0); step(1,1,op,1); end
    endcase
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [15:0] act, req;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        req = exp_ctl(e.st, e.mr, e.rn);
        act = {IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite, IorD, PCWrite,
               PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB};
        checks += 4;
        if (state !== e.st) begin
          errors++; $display("FAIL state cyc=%0d actual=%0d required=%0d", cyc, state, e.st);
        end
        if (act !== req) begin
          errors++; $display("FAIL ctl cyc=%0d st=%0d actual=%b required=%b", cyc, e.st, act, req);
        end
        if (illegal !== e.ill) begin
          errors++; $display("FAIL illegal cyc=%0d actual=%b required=%b", cyc, illegal, e.ill);
        end
        if (retired !== e.ret) begin
          errors++; $display("FAIL retired cyc=%0d actual=%0d required=%0d", cyc, retired, e.ret);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b1; opcode = OP_R;
    e_ill = 1'b0; e_ret = '0;
    @(posedge clk); #1;
    step(0, 1, OP_R, 0);

    // R-type then lw
    do_instr(OP_R);  e_ret = 1;
    do_instr(OP_LW); e_ret = 2;

    // sw with 3 stall cycles in MEMWR
    step(1,1,OP_SW,0); step(1,1,OP_SW,1); step(1,1,OP_SW,2);
    for (int i = 0; i < 3; i++) step(1,0,OP_SW,5);
    step(1,1,OP_SW,5);
    e_ret = 3;

    // j with 3 stall cycles in FETCH
    for (int i = 0; i < 3; i++) step(1,0,OP_J,0);
    step(1,1,OP_J,0); step(1,1,OP_J,1); step(1,1,OP_J,9);
    e_ret = 4;

    do_instr(OP_BEQ);  e_ret = 5;
    do_instr(OP_J);    e_ret = 6;
    do_instr(OP_ADDI); e_ret = 7;

    // Illegal opcode, then R-type with the sticky flag set
    do_instr(OP_BAD); e_ill = 1'b1;
    do_instr(OP_R);   e_ret = 8;

    // Eight jumps take the 4-bit counter 8 -> 15 -> 0
    for (int i = 0; i < 8; i++) begin
      do_instr(OP_J);
      e_ret = (i == 7) ? 4'd0 : 4'(9 + i);
    end
    do_instr(OP_ADDI); e_ret = 1;

    // Reset asserted while in MEMRD
    step(1,1,OP_LW,0); step(1,1,OP_LW,1); step(1,1,OP_LW,2);
    step(0,1,OP_LW,3);
    e_ill = 1'b0; e_ret = 0;
    do_instr(OP_R); e_ret = 1;
    do_instr(OP_SW); e_ret = 2;
    step(1,0,OP_R,0);

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
